// File: rtl/uart_work_rx.sv
// uart_work_rx: hunts a sync byte in the uart byte stream and assembles checksum-verified work packets (rdy/rx_byte in, rdy_clr ack, work_data/work_valid, crc_err, timeout_err out)
module uart_work_rx #(
  parameter int PAYLOAD_BYTES = 44,
  parameter logic [7:0] SYNC_BYTE = 8'h55,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic clk_50m,
  input  logic rst_n,
  input  logic rdy,
  input  logic [7:0] rx_byte,
  output logic rdy_clr,
  output logic [8*PAYLOAD_BYTES-1:0] work_data,
  output logic work_valid,
  output logic crc_err,
  output logic timeout_err
);
  localparam int W = 8*PAYLOAD_BYTES;
  localparam int BW = $clog2(PAYLOAD_BYTES);
  localparam int IW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic [1:0] {HUNT, PAYLOAD, CHECK} state_t;
  state_t state;
  logic [BW-1:0] byte_cnt;
  logic [IW-1:0] idle_cnt;
  logic [7:0] csum;
  logic [W-1:0] shadow;
  logic accept, expire;
  assign accept = rdy && !rdy_clr;
  assign expire = state != HUNT && !accept && idle_cnt == IW'(TIMEOUT_CYCLES-1);
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state <= HUNT;
      byte_cnt <= '0;
      idle_cnt <= '0;
      csum <= '0;
      shadow <= '0;
      rdy_clr <= 1'b0;
      work_data <= '0;
      work_valid <= 1'b0;
      crc_err <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      rdy_clr <= accept;
      work_valid <= 1'b0;
      crc_err <= 1'b0;
      timeout_err <= expire;
      idle_cnt <= (state == HUNT || accept || expire) ? '0 : idle_cnt + 1'b1;
      if (expire) begin
        state <= HUNT;
        byte_cnt <= '0;
      end else if (accept) begin
        case (state)
          HUNT: begin
            state <= (rx_byte == SYNC_BYTE) ? PAYLOAD : HUNT;
            byte_cnt <= '0;
            csum <= '0;
          end
          PAYLOAD: begin
            shadow <= {shadow[W-9:0], rx_byte};
            csum <= csum ^ rx_byte;
            state <= (byte_cnt == BW'(PAYLOAD_BYTES-1)) ? CHECK : PAYLOAD;
            byte_cnt <= (byte_cnt == BW'(PAYLOAD_BYTES-1)) ? '0 : byte_cnt + 1'b1;
          end
          default: begin
            work_data <= (rx_byte == csum) ? shadow : work_data;
            work_valid <= rx_byte == csum;
            crc_err <= rx_byte != csum;
            state <= HUNT;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_work_rx.sv
// tb_uart_work_rx: randomized uart byte stream checked every cycle against a frame-level model
module tb_uart_work_rx;
  localparam int PB = 44;
  localparam int W = 8*PB;
  localparam int T = 64;
  logic clk_50m = 1'b0;
  logic rst_n, rdy, pres;
  logic [7:0] rx_byte;
  logic rdy_clr, work_valid, crc_err, timeout_err;
  logic [W-1:0] work_data;
  int total = 0, bad = 0;
  int n_valid = 0, n_crc = 0, n_to = 0, n_clr = 0;
  logic e_clr, e_valid, e_crc, e_to;
  logic [W-1:0] e_data;
  logic [7:0] pl [PB];
  uart_work_rx #(.PAYLOAD_BYTES(PB), .SYNC_BYTE(8'h55), .TIMEOUT_CYCLES(T)) dut (
    .clk_50m(clk_50m), .rst_n(rst_n), .rdy(rdy), .rx_byte(rx_byte), .rdy_clr(rdy_clr),
    .work_data(work_data), .work_valid(work_valid), .crc_err(crc_err), .timeout_err(timeout_err)
  );
  always #5 clk_50m = ~clk_50m;
  task automatic chk(input string n, input logic [W-1:0] a, input logic [W-1:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask
  initial begin
    bit in_frame;
    int idle;
    logic [7:0] fq [$];
    logic [7:0] x;
    forever begin
      @(posedge clk_50m or negedge rst_n);
      if (!rst_n) begin
        in_frame = 0;
        idle = 0;
        fq.delete();
        {e_clr, e_valid, e_crc, e_to} = '0;
        e_data = '0;
      end else begin
        {e_valid, e_crc, e_to} = '0;
        e_clr = pres;
        if (pres) begin
          idle = 0;
          if (!in_frame) begin
            if (rx_byte == 8'h55) begin
              in_frame = 1;
              fq.delete();
            end
          end else if (fq.size() < PB) fq.push_back(rx_byte);
          else begin
            x = 0;
            foreach (fq[i]) x ^= fq[i];
            if (x == rx_byte) begin
              for (int i = 0; i < PB; i++) e_data[W-8-8*i +: 8] = fq[i];
              e_valid = 1;
            end else e_crc = 1;
            in_frame = 0;
          end
        end else if (in_frame) begin
          idle++;
          if (idle == T) begin
            e_to = 1;
            in_frame = 0;
          end
        end
      end
    end
  end
  always @(negedge clk_50m) if (rst_n) begin
    chk("rdy_clr", W'(rdy_clr), W'(e_clr));
    chk("work_valid", W'(work_valid), W'(e_valid));
    chk("crc_err", W'(crc_err), W'(e_crc));
    chk("timeout_err", W'(timeout_err), W'(e_to));
    chk("work_data", work_data, e_data);
    n_valid += int'(work_valid);
    n_crc += int'(crc_err);
    n_to += int'(timeout_err);
    n_clr += int'(rdy_clr);
  end
  task automatic send(input logic [7:0] b, input int gap);
    rdy = 1;
    rx_byte = b;
    pres = 1;
    @(posedge clk_50m);
    #1 pres = 0;
    @(posedge clk_50m);
    #1 rdy = 0;
    repeat (gap) @(posedge clk_50m);
    #1;
  endtask
  task automatic frame(input logic [7:0] mask, input int gmax, input int pidx, input int plen);
    logic [7:0] x = 0;
    send(8'h55, $urandom_range(gmax, 0));
    for (int i = 0; i < PB; i++) begin
      x ^= pl[i];
      send(pl[i], i == pidx ? plen : $urandom_range(gmax, 0));
    end
    send(x ^ mask, $urandom_range(gmax, 0));
  endtask
  task automatic chk_zero(input string n);
    chk({n, "_rdy_clr"}, W'(rdy_clr), '0);
    chk({n, "_valid"}, W'(work_valid), '0);
    chk({n, "_crc"}, W'(crc_err), '0);
    chk({n, "_to"}, W'(timeout_err), '0);
    chk({n, "_data"}, work_data, '0);
  endtask
  task automatic up;
    for (int i = 0; i < PB; i++) pl[i] = 8'(i + 1);
  endtask
  initial begin
    rst_n = 0;
    rdy = 0;
    pres = 0;
    rx_byte = 0;
    repeat (3) @(posedge clk_50m);
    #1 chk_zero("reset");
    rst_n = 1;
    up();
    frame(8'h00, 0, -1, 0);
    repeat (3) @(posedge clk_50m);
    #1;
    chk("good_count", W'(n_valid), W'(1));
    chk("good_ack_pulses", W'(n_clr), W'(46));
    chk("good_first_byte", W'(work_data[W-1 -: 8]), W'(8'h01));
    chk("good_last_byte", W'(work_data[7:0]), W'(8'h2C));
    frame(8'h2C, 0, -1, 0);
    repeat (3) @(posedge clk_50m);
    #1;
    chk("bad_crc_count", W'(n_crc), W'(1));
    chk("bad_valid_count", W'(n_valid), W'(1));
    chk("bad_data_kept", W'(work_data[7:0]), W'(8'h2C));
    send(8'hAA, 0);
    send(8'h13, 1);
    send(8'h7F, 0);
    frame(8'h00, 1, -1, 0);
    #1 chk("resync_count", W'(n_valid), W'(2));
    send(8'h55, 0);
    for (int i = 0; i < 10; i++) send(pl[i], 0);
    repeat (T + 5) @(posedge clk_50m);
    #1 chk("timeout_count", W'(n_to), W'(1));
    frame(8'h00, 0, -1, 0);
    chk("after_timeout_count", W'(n_valid), W'(3));
    frame(8'h00, 0, 7, T - 2);
    chk("edge_no_timeout", W'(n_to), W'(1));
    chk("edge_valid", W'(n_valid), W'(4));
    frame(8'h00, 0, 7, T - 1);
    chk("edge_timeout", W'(n_to), W'(2));
    send(8'h55, 0);
    for (int i = 0; i < 20; i++) send(pl[i], 0);
    #2 rst_n = 0;
    #1 chk_zero("midreset");
    @(posedge clk_50m);
    #1 rst_n = 1;
    frame(8'h00, 0, -1, 0);
    chk("post_reset_valid", W'(n_valid), W'(5));
    frame(8'h00, 0, -1, 0);
    for (int i = 0; i < PB; i++) pl[i] = 8'(PB - i);
    frame(8'h00, 0, -1, 0);
    repeat (2) @(posedge clk_50m);
    #1;
    chk("b2b_count", W'(n_valid), W'(7));
    chk("b2b_first_byte", W'(work_data[W-1 -: 8]), W'(8'h2C));
    chk("b2b_last_byte", W'(work_data[7:0]), W'(8'h01));
    for (int i = 0; i < PB; i++) pl[i] = 8'h55;
    frame(8'h00, 0, -1, 0);
    chk("sync_as_data", W'(work_data[15:0]), W'(16'h5555));
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(3, 0) == 0) send(8'($urandom), $urandom_range(2, 0));
      for (int i = 0; i < PB; i++) pl[i] = ($urandom_range(7, 0) == 0) ? 8'h55 : 8'($urandom);
      frame(($urandom_range(4, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'h00, 2,
            ($urandom_range(5, 0) == 0) ? int'($urandom_range(PB - 1, 0)) : -1,
            T - 3 + int'($urandom_range(3, 0)));
    end
    repeat (T + 5) @(posedge clk_50m);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
